// File: rtl/dbg_trace_pkg.sv
// Shared encodings for the dispatch-status trace capture unit.
package dbg_trace_pkg;

  localparam int STATUS_W = 2;
  localparam int STATE_W  = 2;

  // Dispatch status of the selected channel for one cycle
  typedef enum logic [STATUS_W-1:0] {
    STS_IDLE = 2'd0,
    STS_RDY  = 2'd1,
    STS_WAIT = 2'd2
  } trc_status_e;

  // Capture controller state, exported on trc_state
  typedef enum logic [STATE_W-1:0] {
    TRC_IDLE    = 2'd0,
    TRC_ARMED   = 2'd1,
    TRC_CAPTURE = 2'd2,
    TRC_DONE    = 2'd3
  } trc_state_e;

endpackage

// File: rtl/trace_ring.sv
// Circular entry buffer: push, pop, clear and overwrite-oldest when full.
// Read data is show-ahead and forced to zero while empty.
module trace_ring #(
  parameter int DEPTH = 64,
  parameter int W     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overwrite
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CW'(DEPTH));
  assign w_pop       = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so the push is not an overwrite
  assign o_overwrite = i_push && o_full && !w_pop;
  assign o_data      = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count     = r_count;

  // Entry storage; no reset needed because reads are masked while empty
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; clear beats any push or pop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop || o_overwrite) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !w_pop && !o_full) r_count <= r_count + 1'b1;
      else if (w_pop && !i_push)       r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/dispatch_trace_buf.sv
// Dispatch-status trace capture: priority channel select, order window,
// duplicate suppression, capture FSM and free-running timestamp.
// Entry layout: {ts, inst, ch_idx, status[1:0], multi}.
//
// state   | meaning
// IDLE    | capture off, buffer contents retained for draining
// ARMED   | buffer cleared, waiting for mon_order to reach window start
// CAPTURE | recording one entry per cycle inside the window
// DONE    | window closed or buffer full in stop mode; waits for cfg_en low
module dispatch_trace_buf
  import dbg_trace_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DEPTH   = 64,
  parameter int INST_W  = 32,
  parameter int ORDER_W = 64,
  parameter int TS_W    = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [ORDER_W-1:0]                   i_mon_order,
  input  logic [INST_W-1:0]                    i_dec_inst,
  input  logic [NUM_CH-1:0]                    i_ch_req,
  input  logic [NUM_CH-1:0]                    i_ch_rdy,
  input  logic                                 i_cfg_en,
  input  logic                                 i_cfg_dedup,
  input  logic                                 i_cfg_stop_full,
  input  logic [ORDER_W-1:0]                   i_cfg_win_start,
  input  logic [ORDER_W-1:0]                   i_cfg_win_end,
  output logic                                 o_rd_valid,
  input  logic                                 i_rd_ready,
  output logic [INST_W+TS_W+$clog2(NUM_CH)+2:0] o_rd_data,
  output logic [1:0]                           o_trc_state,
  output logic [$clog2(DEPTH):0]               o_trc_count,
  output logic                                 o_trc_overflow
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int KEY_W = INST_W + IDX_W + STATUS_W + 1;
  localparam int ENT_W = TS_W + KEY_W;

  trc_state_e        r_state;
  logic              r_en_d;
  logic [TS_W-1:0]   r_ts;
  logic [KEY_W-1:0]  r_last_key;
  logic              r_last_vld;
  logic              r_overflow;

  logic [IDX_W-1:0]  w_sel_idx;
  trc_status_e       w_sel_status;
  logic              w_multi;
  logic [KEY_W-1:0]  w_key;
  logic              w_rise;
  logic              w_win_open;
  logic              w_win_bad;
  logic              w_capturing;
  logic              w_dup;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic              w_overwrite;

  // Lowest-index requesting channel wins; scan from the top so it lands last
  always_comb begin
    w_sel_idx    = '0;
    w_sel_status = STS_IDLE;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_ch_req[i]) begin
        w_sel_idx    = IDX_W'(i);
        w_sel_status = i_ch_rdy[i] ? STS_RDY : STS_WAIT;
      end
    end
  end

  // More than one bit set iff clearing the lowest set bit leaves something
  assign w_multi    = |(i_ch_req & (i_ch_req - 1'b1));
  assign w_key      = {i_dec_inst, w_sel_idx, w_sel_status, w_multi};

  assign w_rise     = i_cfg_en && !r_en_d;
  assign w_win_open = (i_mon_order >= i_cfg_win_start) && (i_mon_order < i_cfg_win_end);
  assign w_win_bad  = (i_cfg_win_start >= i_cfg_win_end);
  // The ARMED cycle that sees the window open is already a capture cycle,
  // so the instruction at cfg_win_start is recorded.
  assign w_capturing = i_cfg_en && ((r_state == TRC_CAPTURE) || (r_state == TRC_ARMED));
  assign w_dup      = i_cfg_dedup && r_last_vld && (w_key == r_last_key);
  assign w_pop      = o_rd_valid && i_rd_ready;
  assign w_push     = w_capturing && w_win_open && !w_dup &&
                      !(i_cfg_stop_full && w_full && !w_pop);

  trace_ring #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_ring (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (w_rise),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_data      ({r_ts, w_key}),
    .o_data      (o_rd_data),
    .o_count     (o_trc_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_overwrite (w_overwrite)
  );

  assign o_rd_valid     = !w_empty;
  assign o_trc_state    = r_state;
  assign o_trc_overflow = r_overflow;

  // Capture controller; dropping cfg_en returns to IDLE from anywhere
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= TRC_IDLE;
    end else if (!i_cfg_en) begin
      r_state <= TRC_IDLE;
    end else begin
      case (r_state)
        TRC_IDLE: begin
          if (w_rise) r_state <= TRC_ARMED;
        end
        TRC_ARMED: begin
          if (w_win_bad)                           r_state <= TRC_DONE;
          else if (i_mon_order >= i_cfg_win_start) r_state <= TRC_CAPTURE;
        end
        TRC_CAPTURE: begin
          if ((i_mon_order >= i_cfg_win_end) || (i_cfg_stop_full && w_full))
            r_state <= TRC_DONE;
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // Timestamp, enable edge detect, dedup reference and sticky overflow
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ts       <= '0;
      r_en_d     <= 1'b0;
      r_last_key <= '0;
      r_last_vld <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ts   <= r_ts + 1'b1;
      r_en_d <= i_cfg_en;
      if (w_rise) begin
        r_last_vld <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) begin
          r_last_key <= w_key;
          r_last_vld <= 1'b1;
        end
        if (w_overwrite) r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_trace_buf.sv
// Bench for dispatch_trace_buf (DEPTH=4): directed scenarios plus randomized
// phases, checked against a queue-based reference model.
module tb_dispatch_trace_buf;

  localparam int DEPTH = 4;
  localparam int EW    = 53;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   mon_order = '0;
  logic [63:0]   win_start = '0;
  logic [63:0]   win_end = '0;
  logic [31:0]   dec_inst = '0;
  logic [3:0]    ch_req = '0;
  logic [3:0]    ch_rdy = '0;
  logic          cfg_en = 1'b0;
  logic          cfg_dedup = 1'b0;
  logic          cfg_stop_full = 1'b0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [EW-1:0] rd_data;
  logic [1:0]    trc_state;
  logic [2:0]    trc_count;
  logic          trc_overflow;

  int total = 0;
  int bad = 0;

  // reference model
  logic [EW-1:0] mq[$];
  int            m_state;
  bit            m_en_d;
  bit            m_ovf;
  bit            m_last_vld;
  logic [36:0]   m_last_key;
  logic [15:0]   m_ts;

  dispatch_trace_buf #(
    .NUM_CH (4), .DEPTH (DEPTH), .INST_W (32), .ORDER_W (64), .TS_W (16)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_mon_order     (mon_order),
    .i_dec_inst      (dec_inst),
    .i_ch_req        (ch_req),
    .i_ch_rdy        (ch_rdy),
    .i_cfg_en        (cfg_en),
    .i_cfg_dedup     (cfg_dedup),
    .i_cfg_stop_full (cfg_stop_full),
    .i_cfg_win_start (win_start),
    .i_cfg_win_end   (win_end),
    .o_rd_valid      (rd_valid),
    .i_rd_ready      (rd_ready),
    .o_rd_data       (rd_data),
    .o_trc_state     (trc_state),
    .o_trc_count     (trc_count),
    .o_trc_overflow  (trc_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_state = 0;
    m_en_d = 1'b0;
    m_ovf = 1'b0;
    m_last_vld = 1'b0;
    m_last_key = '0;
    m_ts = '0;
  endfunction

  // One clock of the specified behaviour, using the inputs sampled at this edge
  function automatic void model_step();
    logic [1:0]  idx = 2'd0;
    logic [1:0]  sts = 2'd0;
    bit          found = 1'b0;
    bit          multi;
    bit          pop;
    bit          full;
    bit          push;
    logic [36:0] key;
    for (int i = 0; i < 4; i++) begin
      if (!found && ch_req[i]) begin
        found = 1'b1;
        idx = 2'(i);
        sts = ch_rdy[i] ? 2'd1 : 2'd2;
      end
    end
    multi = ($countones(ch_req) > 1);
    key = {dec_inst, idx, sts, multi};
    pop = (mq.size() > 0) && rd_ready;
    full = (mq.size() == DEPTH);
    if (!cfg_en) begin
      if (pop) void'(mq.pop_front());
      m_state = 0;
    end else if (!m_en_d) begin
      mq.delete();
      m_ovf = 1'b0;
      m_last_vld = 1'b0;
      m_state = 1;
    end else begin
      push = (m_state == 1 || m_state == 2) &&
             (mon_order >= win_start) && (mon_order < win_end);
      if (push && cfg_dedup && m_last_vld && key == m_last_key) push = 1'b0;
      if (push && cfg_stop_full && full && !pop) push = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() == DEPTH) begin
          void'(mq.pop_front());
          m_ovf = 1'b1;
        end
        mq.push_back({m_ts, key});
        m_last_key = key;
        m_last_vld = 1'b1;
      end
      if (m_state == 1) begin
        if (win_start >= win_end) m_state = 3;
        else if (mon_order >= win_start) m_state = 2;
      end else if (m_state == 2) begin
        if (mon_order >= win_end || (cfg_stop_full && full)) m_state = 3;
      end
    end
    m_en_d = cfg_en;
    m_ts = m_ts + 16'd1;
  endfunction

  task automatic chk_all();
    logic [EW-1:0] exp_data;
    exp_data = (mq.size() > 0) ? mq[0] : '0;
    chk("state", 64'(trc_state), 64'(m_state));
    chk("count", 64'(trc_count), 64'(mq.size()));
    chk("overflow", 64'(trc_overflow), 64'(m_ovf));
    chk("rd_valid", 64'(rd_valid), 64'(mq.size() > 0));
    chk("rd_data", 64'(rd_data), 64'(exp_data));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    chk_all();
  endtask

  task automatic arm();
    cfg_en = 1'b0;
    cyc();
    cfg_en = 1'b1;
    cyc();
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    repeat (DEPTH + 1) cyc();
    rd_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 64'(trc_state), 64'd0);
    chk({tag, "_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_data"}, 64'(rd_data), 64'd0);
    chk({tag, "_count"}, 64'(trc_count), 64'd0);
    chk({tag, "_ovf"}, 64'(trc_overflow), 64'd0);
  endtask

  initial begin
    logic [15:0]   ts0;
    logic [15:0]   ts1;
    logic [EW-1:0] prev_data;
    bit            prev_stall;

    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    cyc();

    // order window 2000..2003 stepped one per cycle
    ch_req = 4'b0001; ch_rdy = 4'b0001; dec_inst = 32'hCAFE_0001;
    win_start = 64'd2000; win_end = 64'd2003; mon_order = 64'd1990;
    arm();
    for (int m = 1998; m <= 2005; m++) begin
      mon_order = 64'(m);
      cyc();
    end
    chk("win_count", 64'(trc_count), 64'd3);
    chk("win_state", 64'(trc_state), 64'd3);
    for (int k = 0; k < 3; k++) begin
      chk("win_status", 64'(rd_data[2:1]), 64'd1);
      chk("win_idx", 64'(rd_data[4:3]), 64'd0);
      rd_ready = 1'b1;
      cyc();
      rd_ready = 1'b0;
    end
    cfg_en = 1'b0;
    cyc();
    chk("idle_state", 64'(trc_state), 64'd0);

    // priority and multi-request, then no request
    win_start = 64'd0; win_end = 64'd1000; mon_order = 64'd10;
    arm();
    ch_req = 4'b1100; ch_rdy = 4'b0100;
    cyc();
    ch_req = 4'b0000; ch_rdy = 4'b0000;
    cyc();
    cfg_en = 1'b0;
    cyc();
    chk("prio_idx", 64'(rd_data[4:3]), 64'd2);
    chk("prio_status", 64'(rd_data[2:1]), 64'd1);
    chk("prio_multi", 64'(rd_data[0]), 64'd1);
    rd_ready = 1'b1;
    cyc();
    rd_ready = 1'b0;
    chk("noreq_status", 64'(rd_data[2:1]), 64'd0);
    chk("noreq_multi", 64'(rd_data[0]), 64'd0);
    drain();

    // dedup: LSU WAIT held 10 cycles, then RDY
    cfg_dedup = 1'b1; dec_inst = 32'h0000_0013;
    ch_req = 4'b0100; ch_rdy = 4'b0000;
    arm();
    repeat (10) cyc();
    ch_rdy = 4'b0100;
    cyc();
    cfg_en = 1'b0;
    cyc();
    chk("dedup_count", 64'(trc_count), 64'd2);
    chk("dedup_first", 64'(rd_data[2:1]), 64'd2);
    ts0 = rd_data[52:37];
    rd_ready = 1'b1;
    cyc();
    rd_ready = 1'b0;
    chk("dedup_second", 64'(rd_data[2:1]), 64'd1);
    ts1 = rd_data[52:37];
    chk("dedup_dt", 64'(ts1 - ts0), 64'd10);
    drain();
    cfg_dedup = 1'b0;

    // overwrite mode: six writes into four slots
    cfg_stop_full = 1'b0; ch_req = 4'b0001; ch_rdy = 4'b0001;
    arm();
    for (int k = 0; k < 6; k++) begin
      dec_inst = 32'(100 + k);
      cyc();
    end
    cfg_en = 1'b0;
    cyc();
    chk("ovw_count", 64'(trc_count), 64'd4);
    chk("ovw_flag", 64'(trc_overflow), 64'd1);
    chk("ovw_first", 64'(rd_data[36:5]), 64'd102);
    drain();

    // stop-at-full mode
    cfg_stop_full = 1'b1;
    arm();
    for (int k = 0; k < 6; k++) begin
      dec_inst = 32'(100 + k);
      cyc();
    end
    chk("stop_state", 64'(trc_state), 64'd3);
    chk("stop_count", 64'(trc_count), 64'd4);
    chk("stop_ovf", 64'(trc_overflow), 64'd0);
    chk("stop_first", 64'(rd_data[36:5]), 64'd100);
    drain();

    // empty window goes straight to DONE
    win_start = 64'd50; win_end = 64'd50; mon_order = 64'd60;
    arm();
    cyc();
    chk("badwin_state", 64'(trc_state), 64'd3);
    chk("badwin_count", 64'(trc_count), 64'd0);

    // randomized phases with backpressure
    for (int ph = 0; ph < 6; ph++) begin
      cfg_en = 1'b0;
      cyc();
      win_start = 64'($urandom_range(0, 20));
      win_end = 64'($urandom_range(0, 60));
      mon_order = '0;
      cfg_dedup = (ph == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      cfg_stop_full = (ph == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (ph == 0) win_start = '0;
      if (ph == 0) win_end = 64'd1000;
      cfg_en = 1'b1;
      for (int c = 0; c < 50; c++) begin
        ch_req = 4'($urandom);
        ch_rdy = 4'($urandom);
        dec_inst = 32'($urandom_range(0, 3));
        rd_ready = (ph == 0) ? 1'(c % 2) : ($urandom_range(0, 3) != 0);
        prev_stall = (c != 0) && rd_valid && !rd_ready && (trc_count < 3'(DEPTH));
        prev_data = rd_data;
        cyc();
        if (prev_stall) chk("stall_hold", 64'(rd_data), 64'(prev_data));
        mon_order = mon_order + 64'($urandom_range(0, 2));
      end
      rd_ready = 1'b0;
    end

    // asynchronous reset in the middle of a capture
    cfg_en = 1'b0; cfg_dedup = 1'b0; cfg_stop_full = 1'b0;
    win_start = '0; win_end = 64'd1000; mon_order = 64'd10;
    ch_req = 4'b0010; ch_rdy = 4'b0000; dec_inst = $urandom;
    arm();
    repeat (2) cyc();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    model_reset();
    cyc();
    rst_n = 1'b1;
    cyc();

    // re-arm with data held and overflow set clears both, even with a pop
    for (int k = 0; k < 5; k++) begin
      dec_inst = $urandom;
      cyc();
    end
    cfg_en = 1'b0;
    cyc();
    chk("held_count", 64'(trc_count), 64'd4);
    chk("held_ovf", 64'(trc_overflow), 64'd1);
    rd_ready = 1'b1;
    cfg_en = 1'b1;
    cyc();
    rd_ready = 1'b0;
    chk("rearm_count", 64'(trc_count), 64'd0);
    chk("rearm_ovf", 64'(trc_overflow), 64'd0);
    chk("rearm_valid", 64'(rd_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dispatch_trace_buf.md
# dispatch_trace_buf

Synthesizable, parametrised dispatch-status trace capture unit for the OoO core. Every cycle it samples the decoder's instruction word and the req/rdy handshakes of NUM_CH reservation-station dispatch channels. Inside a programmable instruction-order window, it records one entry per cycle into a circular buffer, with optional duplicate suppression and stop-or-overwrite behaviour when full. The entries are drained through a valid/ready stream, so dispatch stalls can be observed on silicon/FPGA as well as in simulation.

## Interface
- NUM_CH, 4, number of dispatch channels (ALU, MDU, LSU, JMP order = index 0..3)
- DEPTH, 64, buffer entries; power of two, ≥ 2
- INST_W, 32, instruction word width
- ORDER_W, 64, instruction order counter width
- TS_W, 16, timestamp width (free-running cycle count, wraps)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mon_order  in  ORDER_W  order of instruction currently at ROB monitor
- dec_inst  in  INST_W  instruction word at decode
- ch_req  in  NUM_CH  per-channel dispatch request
- ch_rdy  in  NUM_CH  per-channel dispatch ready
- cfg_en  in  1  capture enable; rising edge re-arms
- cfg_dedup  in  1  suppress entry identical to previous written entry
- cfg_stop_full  in  1  1 = stop at full, 0 = overwrite oldest
- cfg_win_start  in  ORDER_W  first order captured (inclusive)
- cfg_win_end  in  ORDER_W  capture ends when mon_order ≥ this
- rd_valid  out  1  entry available
- rd_ready  in  1  consumer accepts entry
- rd_data  out  INST_W+TS_W+$clog2(NUM_CH)+3  {ts, inst, ch_idx, status[1:0], multi}
- trc_state  out  2  IDLE/ARMED/CAPTURE/DONE
- trc_count  out  $clog2(DEPTH)+1  entries held
- trc_overflow  out  1  sticky: ≥1 entry overwritten

## Operation
- Channel select: lowest index i with ch_req[i]=1 wins; ch_idx=i; status RDY(1) if ch_rdy[i] else WAIT(2); multi=1 if more than one req bit set. No req: ch_idx=0, status IDLE(0), multi=0.
- FSM: IDLE → ARMED on cfg_en rising edge (clears rd/wr pointers, count, overflow). ARMED → CAPTURE when mon_order ≥ cfg_win_start. CAPTURE → DONE when mon_order ≥ cfg_win_end, or when full with cfg_stop_full=1. Any state → IDLE when cfg_en=0. DONE holds until cfg_en drops.
- If cfg_win_start ≥ cfg_win_end: ARMED → DONE directly; nothing is written.
- Write: every CAPTURE cycle in which the window condition holds (start ≤ mon_order < end). Skip the write if cfg_dedup=1 and {inst, ch_idx, status, multi} equals the last written entry. The timestamp exposes the gap. The dedup reference resets on re-arm.
- Full + write, cfg_stop_full=0: overwrite oldest, advance read pointer, set trc_overflow. If rd_ready&&rd_valid in the same cycle, the pop absorbs the slot: no overwrite, no overflow.
- Read: a pop occurs when rd_valid&&rd_ready. Reads are legal in every state. Buffer contents are retained in IDLE and DONE until the next re-arm.
- Re-arm and pop in the same cycle: clear wins.
- Timestamp: TS_W counter running from reset; it wraps silently.

## Timing
- Reset values: trc_state=IDLE, rd_valid=0, rd_data=0, trc_count=0, trc_overflow=0, timestamp=0, pointers=0.
- Inputs are sampled at posedge. A written entry is visible on rd_valid/rd_data the next cycle when the buffer was empty (1-cycle latency).
- rd_data is show-ahead and stable while rd_valid&&!rd_ready.
- State transitions take effect the cycle after the condition. The write in the cycle that detects mon_order ≥ cfg_win_end is suppressed.
- trc_count updates the same cycle as the pointers, with simultaneous push+pop netting zero.
- Asynchronous reset mid-capture drops everything and returns to IDLE immediately.

## Structure
- New package dbg_trace_pkg: trc_status_e (IDLE=0, RDY=1, WAIT=2), trc_state_e, status encoding widths. Entry packing stays local because it depends on the parameters.
- Sub-module trace_ring: DEPTH×W circular buffer with push, pop, clear, and overwrite-on-full, plus count/full/empty outputs.
- Top level holds the priority select, dedup compare, window compare, FSM and timestamp.

## Test plan
- Window: cfg_win_start=2000, cfg_win_end=2003, mon_order steps 1998..2005, ch_req=4'b0001, ch_rdy=1 → exactly 3 entries, status=RDY, ch_idx=0; trc_state=DONE.
- Priority/multi: ch_req=4'b1100, ch_rdy=4'b0100 → ch_idx=2, status=RDY, multi=1; then ch_req=0 → status IDLE.
- Dedup: cfg_dedup=1, same inst 0x00000013 with LSU WAIT held for 10 cycles, then RDY → 2 entries; timestamp delta=10.
- Overwrite: DEPTH=4, cfg_stop_full=0, write 6 entries with no reads → count=4, overflow=1, first read = 3rd entry. Repeat with cfg_stop_full=1 → first 4 kept, DONE after full.
- Backpressure: rd_ready toggling 1/0 during capture → rd_data stable while stalled, no loss, count matches pushes minus pops.
- Reset/re-arm: assert rst_n low mid-capture → all outputs at reset values. cfg_en 0→1 with 3 entries held → count=0, overflow=0.
